// File: rtl/dotmatrix_scroller_if.sv
// Glyph-code stream and scanner row port of the dot-matrix scroller.
// The master side is the code source plus the row scanner.
interface dotmatrix_scroller_if;
   logic [3:0] code;
   logic       code_valid;
   logic       code_ready;
   logic       frame_sync;
   logic [2:0] row_sel;
   logic [7:0] row_data;

   modport master (
      output code, code_valid, frame_sync, row_sel,
      input  code_ready, row_data
   );

   modport slave (
      input  code, code_valid, frame_sync, row_sel,
      output code_ready, row_data
   );
endinterface

// File: rtl/dotmatrix_scroller.sv
// Glyph FIFO, ROM expansion and one-column-per-step left scroll.
// The front buffer is refreshed only at frame wrap, so the scanner sees whole frames.
module dotmatrix_scroller #(
   parameter int STEP_TICKS = 2700000,
   parameter int GAP_COLS   = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic CLK,
   input  logic RESETn,
   input  logic i_clear,
   dotmatrix_scroller_if.slave bus,
   output logic o_busy
);

   localparam int CW = $clog2(STEP_TICKS);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int GW = (GAP_COLS > 1) ? $clog2(GAP_COLS) : 1;

   typedef enum logic [1:0] {IDLE, GLYPH, GAP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          step;
   logic [3:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wp, rp;
   logic          empty, full, push, pop;
   logic [3:0]    head, glyph;
   logic [2:0]    col;
   logic [GW-1:0] gap;
   logic [7:0]    back  [8];
   logic [7:0]    front [8];
   logic [7:0]    colbit;
   logic          pending, copy;

   // Row r of glyph g, packed with row 0 in the top byte.
   function automatic logic [7:0] rom(input logic [3:0] g,
                                      input logic [2:0] r);
      logic [63:0] w;
      unique case (g)
         4'd0:    w = 64'h0000000000000000;
         4'd1:    w = 64'hAA55AA55AA55AA55;
         4'd2:    w = 64'h3C42424242423C00;
         4'd3:    w = 64'h1838181818187E00;
         4'd4:    w = 64'h3C42020C30407E00;
         4'd5:    w = 64'h3C42021C02423C00;
         4'd6:    w = 64'h0C1424447E040400;
         4'd7:    w = 64'h7E40407C02423C00;
         4'd8:    w = 64'h1C20407C42423C00;
         4'd9:    w = 64'h7E02040810101000;
         4'd10:   w = 64'h3C42423C42423C00;
         4'd11:   w = 64'h3C42423E02043800;
         4'd12:   w = 64'h183C7EFFFF7E3C18;
         4'd13:   w = 64'h8142241818244281;
         4'd14:   w = 64'hFF818181818181FF;
         default: w = 64'hFFFFFFFFFFFFFFFF;
      endcase
      return w[{~r, 3'b000} +: 8];
   endfunction

   function automatic logic rom_bit(input logic [3:0] g,
                                    input logic [2:0] r,
                                    input logic [2:0] c);
      logic [7:0] rw;
      rw = rom(g, r);
      return rw[~c];
   endfunction

   assign step           = cnt == CW'(STEP_TICKS - 1);
   assign empty          = wp == rp;
   assign full           = (wp[AW] != rp[AW]) &&
                           (wp[AW-1:0] == rp[AW-1:0]);
   assign bus.code_ready = !full;
   assign push           = bus.code_valid && !full;
   assign pop            = step && state == IDLE && !empty;
   assign head           = mem[rp[AW-1:0]];
   assign copy           = bus.frame_sync && pending;
   assign o_busy         = state != IDLE || !empty;

   always_comb begin
      colbit = '0;
      for (int r = 0; r < 8; r++) begin
         unique case (state)
            IDLE:    colbit[r] = !empty && rom_bit(head, 3'(r), 3'd0);
            GLYPH:   colbit[r] = rom_bit(glyph, 3'(r), col);
            default: colbit[r] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn)      cnt <= '0;
      else if (i_clear) cnt <= '0;
      else if (step)    cnt <= '0;
      else              cnt <= cnt + CW'(1);
   end

   always_ff @(posedge CLK) begin
      if (push && !i_clear) mem[wp[AW-1:0]] <= bus.code;
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         wp <= '0;
         rp <= '0;
      end else if (i_clear) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state   <= IDLE;
         glyph   <= '0;
         col     <= '0;
         gap     <= '0;
         pending <= 1'b0;
         for (int r = 0; r < 8; r++) begin
            back[r]  <= '0;
            front[r] <= '0;
         end
      end else if (i_clear) begin
         state   <= IDLE;
         glyph   <= '0;
         col     <= '0;
         gap     <= '0;
         pending <= 1'b0;
         for (int r = 0; r < 8; r++) begin
            back[r]  <= '0;
            front[r] <= '0;
         end
      end else begin
         // A copy in a step cycle takes the pre-shift image.
         if (copy)
            for (int r = 0; r < 8; r++) front[r] <= back[r];
         if (step) begin
            for (int r = 0; r < 8; r++)
               back[r] <= {back[r][6:0], colbit[r]};
            pending <= 1'b1;
            unique case (state)
               IDLE: if (!empty) begin
                  glyph <= head;
                  col   <= 3'd1;
                  state <= GLYPH;
               end
               GLYPH: if (col == 3'd7) begin
                  gap   <= '0;
                  state <= GAP;
               end else begin
                  col <= col + 3'd1;
               end
               GAP: if (gap == GW'(GAP_COLS - 1)) state <= IDLE;
                    else gap <= gap + GW'(1);
               default: state <= IDLE;
            endcase
         end else if (copy) begin
            pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn)      bus.row_data <= '0;
      else if (i_clear) bus.row_data <= '0;
      else if (copy)    bus.row_data <= back[bus.row_sel];
      else              bus.row_data <= front[bus.row_sel];
   end

endmodule

// File: tb/tb_dotmatrix_scroller.sv
// Directed bench for dotmatrix_scroller with STEP_TICKS=4, GAP_COLS=1.
// ph tracks the prescaler phase; an edge taken with ph==3 is a step.
module tb_dotmatrix_scroller;

   logic CLK = 1'b0;
   logic RESETn = 1'b0;
   logic i_clear = 1'b0;
   logic o_busy;
   int   ph = 0;
   int   checks = 0;
   int   failures = 0;

   dotmatrix_scroller_if bus ();

   dotmatrix_scroller #(
      .STEP_TICKS(4),
      .GAP_COLS(1),
      .FIFO_DEPTH(4)
   ) dut (
      .CLK(CLK),
      .RESETn(RESETn),
      .i_clear(i_clear),
      .bus(bus),
      .o_busy(o_busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
      ph = (ph + 1) % 4;
   endtask

   task automatic steps(input int n);
      int k;
      k = n;
      while (k > 0) begin
         if (ph == 3) k--;
         cyc();
      end
   endtask

   task automatic push(input logic [3:0] c);
      bus.code       = c;
      bus.code_valid = 1'b1;
      cyc();
      bus.code_valid = 1'b0;
   endtask

   task automatic sync();
      bus.frame_sync = 1'b1;
      cyc();
      bus.frame_sync = 1'b0;
   endtask

   task automatic clr();
      i_clear = 1'b1;
      cyc();
      i_clear = 1'b0;
      ph = 0;
   endtask

   task automatic rows(input string tag, input logic [7:0] ev,
                       input logic [7:0] od);
      for (int r = 0; r < 8; r++) begin
         bus.row_sel = 3'(r);
         cyc();
         chk($sformatf("%s_r%0d", tag, r), bus.row_data,
             r[0] ? od : ev);
      end
      bus.row_sel = 3'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      bus.code       = 4'd0;
      bus.code_valid = 1'b0;
      bus.frame_sync = 1'b0;
      bus.row_sel    = 3'd0;

      // reset state
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_row", bus.row_data, 8'h00);
      chk("rst_ready", 8'(bus.code_ready), 8'h01);
      chk("rst_busy", 8'(o_busy), 8'h00);
      RESETn = 1'b1;
      ph = 0;
      sync();
      rows("idle", 8'h00, 8'h00);
      chk("idle_busy", 8'(o_busy), 8'h00);

      // solid glyph fills every row after 8 steps
      clr();
      push(4'd15);
      chk("g15_busy0", 8'(o_busy), 8'h01);
      steps(8);
      chk("g15_busy8", 8'(o_busy), 8'h01);
      sync();
      rows("g15", 8'hFF, 8'hFF);
      chk("g15_idle", 8'(o_busy), 8'h00);

      // checker glyph, then drain to blank
      clr();
      push(4'd1);
      steps(8);
      sync();
      rows("g1", 8'hAA, 8'h55);
      steps(8);
      sync();
      rows("drain", 8'h00, 8'h00);

      // FIFO fill while a glyph is scrolling
      clr();
      push(4'd15);
      steps(1);
      push(4'd1);
      push(4'd2);
      push(4'd3);
      chk("f3_ready", 8'(bus.code_ready), 8'h01);
      push(4'd4);
      chk("full_ready", 8'(bus.code_ready), 8'h00);
      chk("full_busy", 8'(o_busy), 8'h01);
      bus.code       = 4'd5;
      bus.code_valid = 1'b1;
      cyc();
      cyc();
      chk("held_ready", 8'(bus.code_ready), 8'h00);
      steps(7);
      chk("prepop_ready", 8'(bus.code_ready), 8'h00);
      steps(1);
      chk("pop_ready", 8'(bus.code_ready), 8'h01);
      cyc();
      chk("refill_ready", 8'(bus.code_ready), 8'h00);
      bus.code_valid = 1'b0;

      // sync coinciding with a step
      clr();
      push(4'd15);
      steps(1);
      cyc();
      cyc();
      cyc();
      bus.frame_sync = 1'b1;
      cyc();
      bus.frame_sync = 1'b0;
      chk("sync_step", bus.row_data, 8'h01);
      sync();
      chk("sync_after", bus.row_data, 8'h03);
      sync();
      chk("sync_nopend", bus.row_data, 8'h03);

      // clear mid-glyph with three codes queued
      clr();
      push(4'd15);
      steps(1);
      sync();
      chk("pre_clr_row", bus.row_data, 8'h01);
      push(4'd2);
      push(4'd3);
      push(4'd4);
      chk("pre_clr_busy", 8'(o_busy), 8'h01);
      i_clear        = 1'b1;
      bus.code       = 4'd7;
      bus.code_valid = 1'b1;
      bus.frame_sync = 1'b1;
      cyc();
      i_clear        = 1'b0;
      bus.code_valid = 1'b0;
      bus.frame_sync = 1'b0;
      ph = 0;
      chk("clr_row", bus.row_data, 8'h00);
      chk("clr_ready", 8'(bus.code_ready), 8'h01);
      chk("clr_busy", 8'(o_busy), 8'h00);
      steps(2);
      chk("clr_busy2", 8'(o_busy), 8'h00);

      // asynchronous reset mid-glyph
      clr();
      push(4'd15);
      steps(1);
      sync();
      push(4'd2);
      push(4'd3);
      push(4'd4);
      chk("pre_rst_row", bus.row_data, 8'h01);
      RESETn = 1'b0;
      #2;
      chk("arst_row", bus.row_data, 8'h00);
      chk("arst_ready", 8'(bus.code_ready), 8'h01);
      chk("arst_busy", 8'(o_busy), 8'h00);
      cyc();
      RESETn = 1'b1;
      ph = 0;
      steps(2);
      chk("arst_busy2", 8'(o_busy), 8'h00);
      sync();
      chk("arst_sync_row", bus.row_data, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
